// File: rtl/insn_encoder_loader.sv
// insn_encoder_loader
//
// Turns instruction field tuples into 16-bit Simple RISC Machine words and
// writes them one after another into instruction RAM through a single write
// port. The bit layout is the one the CPU decoder extracts:
//   [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm
//
// Handshake: a tuple is accepted on a rising clock edge when in_valid and
// in_ready are both high. Inputs are sampled only at acceptance. The producer
// may hold in_valid; in_ready drops for the write cycle, so the best rate is
// one word every two cycles.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   restart          synchronous return to IDLE, counters and err cleared
//   in_valid/ready   tuple handshake
//   mnem,rn,rd,rm,sh,imm   instruction fields (mnem 9..15 illegal)
//   mem_wr_en        one-cycle write strobe per word
//   mem_addr         write address (BASE_ADDR + count, wraps at ADDR_W)
//   mem_wdata        encoded word, held while mem_wr_en is low
//   count            words written since reset/restart
//   err              sticky: a tuple was rejected
//   done             HALT written or DEPTH words written
module insn_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        mnem,
    input  logic [2:0]        rn,
    input  logic [2:0]        rd,
    input  logic [2:0]        rm,
    input  logic [1:0]        sh,
    input  logic [7:0]        imm,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic              done
);

    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                err_q, err_d;
    logic                done_q, done_d;

    logic [15:0]         enc_word;
    logic                enc_legal;
    logic                imm5_ok;

    // Field encoder. Fields a mnemonic does not use are forced to zero.
    always_comb begin
        // imm5 is a signed 5-bit value carried in an 8-bit field: the upper
        // three bits must be copies of bit 4.
        imm5_ok   = (imm[7:5] == {3{imm[4]}});
        enc_word  = 16'h0000;
        enc_legal = 1'b1;
        case (mnem)
            4'd0: enc_word = {3'b110, 2'b10, rn, imm};
            4'd1: enc_word = {3'b110, 2'b00, 3'b000, rd, sh, rm};
            4'd2: enc_word = {3'b101, 2'b00, rn, rd, sh, rm};
            4'd3: enc_word = {3'b101, 2'b01, rn, 3'b000, sh, rm};
            4'd4: enc_word = {3'b101, 2'b10, rn, rd, sh, rm};
            4'd5: enc_word = {3'b101, 2'b11, 3'b000, rd, sh, rm};
            4'd6: begin
                enc_word  = {3'b011, 2'b00, rn, rd, imm[4:0]};
                enc_legal = imm5_ok;
            end
            4'd7: begin
                enc_word  = {3'b100, 2'b00, rn, rd, imm[4:0]};
                enc_legal = imm5_ok;
            end
            4'd8: enc_word = {3'b111, 13'b0};
            default: enc_legal = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (enc_legal) begin
                        wdata_d = enc_word;
                        state_d = S_WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + 1'b1;
                count_d = count_q + 1'b1;
                // Opcode 111 is only ever produced by HALT.
                if (wdata_q[15:13] == 3'b111 || count_d == DEPTH_C) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        // restart overrides everything; a strobe already on the port this
        // cycle still completes because mem_wr_en comes from state_q.
        if (restart) begin
            state_d = S_IDLE;
            addr_d  = BASE_C;
            count_d = '0;
            err_d   = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= BASE_C;
            count_q <= '0;
            wdata_q <= 16'h0000;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign mem_wr_en = (state_q == S_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign err       = err_q;
    assign done      = done_q;

endmodule

// File: tb/tb_insn_encoder_loader.sv
// Bench for insn_encoder_loader. Two instances share the input bus: u_big
// with default parameters and u_small with DEPTH = 4 for the full condition.
module tb_insn_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n, restart, in_valid;
    logic [3:0]  mnem;
    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh;
    logic [7:0]  imm;

    logic        b_ready, b_wr, b_err, b_done;
    logic [7:0]  b_addr;
    logic [15:0] b_wdata;
    logic [8:0]  b_count;
    logic        s_ready, s_wr, s_err, s_done;
    logic [7:0]  s_addr;
    logic [15:0] s_wdata;
    logic [8:0]  s_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          exp_count;
    int          exp_addr;
    logic        exp_err, exp_done;
    logic [15:0] last_w;
    bit          have_w;

    insn_encoder_loader u_big (
        .clk(clk), .rst_n(rst_n), .restart(restart), .in_valid(in_valid),
        .in_ready(b_ready), .mnem(mnem), .rn(rn), .rd(rd), .rm(rm), .sh(sh),
        .imm(imm), .mem_wr_en(b_wr), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .count(b_count), .err(b_err), .done(b_done)
    );

    insn_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0), .DEPTH(4)) u_small (
        .clk(clk), .rst_n(rst_n), .restart(restart), .in_valid(in_valid),
        .in_ready(s_ready), .mnem(mnem), .rn(rn), .rd(rd), .rm(rm), .sh(sh),
        .imm(imm), .mem_wr_en(s_wr), .mem_addr(s_addr), .mem_wdata(s_wdata),
        .count(s_count), .err(s_err), .done(s_done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference encoder ----------------
    // Builds the word arithmetically from field weights; returns {legal, word}.
    function automatic logic [16:0] model_enc(input int m, input int a_rn, input int a_rd,
                                              input int a_rm, input int a_sh, input int a_imm);
        int w;
        bit legal;
        int simm;
        legal = 1;
        simm  = (a_imm >= 128) ? a_imm - 256 : a_imm;
        case (m)
            0: w = 6*8192 + 2*2048 + a_rn*256 + a_imm;
            1: w = 6*8192 + a_rd*32 + a_sh*8 + a_rm;
            2: w = 5*8192 + a_rn*256 + a_rd*32 + a_sh*8 + a_rm;
            3: w = 5*8192 + 1*2048 + a_rn*256 + a_sh*8 + a_rm;
            4: w = 5*8192 + 2*2048 + a_rn*256 + a_rd*32 + a_sh*8 + a_rm;
            5: w = 5*8192 + 3*2048 + a_rd*32 + a_sh*8 + a_rm;
            6: begin
                w = 3*8192 + a_rn*256 + a_rd*32 + (a_imm % 32);
                legal = (simm >= -16 && simm <= 15);
            end
            7: begin
                w = 4*8192 + a_rn*256 + a_rd*32 + (a_imm % 32);
                legal = (simm >= -16 && simm <= 15);
            end
            8: w = 7*8192;
            default: begin
                w = 0;
                legal = 0;
            end
        endcase
        return {legal, 16'(w)};
    endfunction

    // ---------------- driver tasks ----------------
    // Presents one tuple for exactly one clock edge; returns on the next
    // falling edge, where a legal accepted tuple is in its write cycle.
    task automatic send(input int m, input int a_rn, input int a_rd, input int a_rm,
                        input int a_sh, input int a_imm);
        @(negedge clk);
        mnem = 4'(m); rn = 3'(a_rn); rd = 3'(a_rd); rm = 3'(a_rm);
        sh = 2'(a_sh); imm = 8'(a_imm);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        mnem = 4'($urandom); rn = 3'($urandom); rd = 3'($urandom);
        rm = 3'($urandom); sh = 2'($urandom); imm = 8'($urandom);
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        exp_count = 0; exp_addr = 0; exp_err = 1'b0; exp_done = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %0b want 1", b_ready); end
        n_cmp++; if (b_wr !== 1'b0) begin n_bad++; $display("FAIL reset_wr got %0b want 0", b_wr); end
        n_cmp++; if (b_addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr got %0h want 0", b_addr); end
        n_cmp++; if (b_wdata !== 16'h0000) begin n_bad++; $display("FAIL reset_wdata got %0h want 0", b_wdata); end
        n_cmp++; if (b_count !== 9'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", b_count); end
        n_cmp++; if (b_err !== 1'b0 || b_done !== 1'b0) begin n_bad++; $display("FAIL reset_flags got err=%0b done=%0b want 0 0", b_err, b_done); end
        n_cmp++; if (s_count !== 9'd0 || s_done !== 1'b0) begin n_bad++; $display("FAIL reset_small got count=%0d done=%0b want 0 0", s_count, s_done); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        send(0, 0, 0, 0, 0, 8'h07);
        n_cmp++; if (b_wr !== 1'b1) begin n_bad++; $display("FAIL mov_wr got %0b want 1", b_wr); end
        n_cmp++; if (b_addr !== 8'h00) begin n_bad++; $display("FAIL mov_addr got %0h want 0", b_addr); end
        n_cmp++; if (b_wdata !== 16'hD007) begin n_bad++; $display("FAIL mov_wdata got %0h want d007", b_wdata); end
        n_cmp++; if (b_ready !== 1'b0) begin n_bad++; $display("FAIL mov_ready_write got %0b want 0", b_ready); end
        @(negedge clk);
        n_cmp++; if (b_wr !== 1'b0) begin n_bad++; $display("FAIL mov_wr_after got %0b want 0", b_wr); end
        n_cmp++; if (b_count !== 9'd1) begin n_bad++; $display("FAIL mov_count got %0d want 1", b_count); end
        n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL mov_ready_after got %0b want 1", b_ready); end
        n_cmp++; if (b_wdata !== 16'hD007) begin n_bad++; $display("FAIL mov_hold got %0h want d007", b_wdata); end
        do_restart();
        send(2, 1, 2, 3, 1, 0);
        n_cmp++; if (b_wr !== 1'b1 || b_addr !== 8'h00 || b_wdata !== 16'hA14B) begin n_bad++; $display("FAIL add_word got wr=%0b addr=%0h data=%0h want 1 0 a14b", b_wr, b_addr, b_wdata); end
        @(negedge clk);
        send(6, 5, 6, 0, 0, 8'hF0);
        n_cmp++; if (b_wr !== 1'b1 || b_addr !== 8'h01 || b_wdata !== 16'h65D0) begin n_bad++; $display("FAIL ldr_word got wr=%0b addr=%0h data=%0h want 1 1 65d0", b_wr, b_addr, b_wdata); end
        @(negedge clk);
        n_cmp++; if (b_count !== 9'd2) begin n_bad++; $display("FAIL ldr_count got %0d want 2", b_count); end
    endtask

    task automatic test_reject();
        send(6, 1, 1, 0, 0, 8'h30);
        n_cmp++; if (b_wr !== 1'b0 || b_err !== 1'b1) begin n_bad++; $display("FAIL rej_imm got wr=%0b err=%0b want 0 1", b_wr, b_err); end
        n_cmp++; if (b_count !== 9'd2 || b_wdata !== 16'h65D0) begin n_bad++; $display("FAIL rej_imm_state got count=%0d data=%0h want 2 65d0", b_count, b_wdata); end
        @(negedge clk);
        n_cmp++; if (b_wr !== 1'b0) begin n_bad++; $display("FAIL rej_imm_late got %0b want 0", b_wr); end
        send(12, 1, 1, 1, 1, 1);
        n_cmp++; if (b_wr !== 1'b0 || b_err !== 1'b1 || b_count !== 9'd2) begin n_bad++; $display("FAIL rej_mnem got wr=%0b err=%0b count=%0d want 0 1 2", b_wr, b_err, b_count); end
        send(1, 7, 3, 5, 2, 8'hFF);
        n_cmp++; if (b_wr !== 1'b1 || b_addr !== 8'h02 || b_wdata !== 16'hC075) begin n_bad++; $display("FAIL after_rej got wr=%0b addr=%0h data=%0h want 1 2 c075", b_wr, b_addr, b_wdata); end
        @(negedge clk);
        n_cmp++; if (b_count !== 9'd3 || b_err !== 1'b1) begin n_bad++; $display("FAIL after_rej_state got count=%0d err=%0b want 3 1", b_count, b_err); end
    endtask

    task automatic test_halt();
        do_restart();
        n_cmp++; if (b_err !== 1'b0) begin n_bad++; $display("FAIL restart_err got %0b want 0", b_err); end
        send(3, 7, 5, 2, 0, 0);
        n_cmp++; if (b_wr !== 1'b1 || b_addr !== 8'h00 || b_wdata !== 16'hAF02) begin n_bad++; $display("FAIL cmp_word got wr=%0b addr=%0h data=%0h want 1 0 af02", b_wr, b_addr, b_wdata); end
        @(negedge clk);
        send(8, 7, 7, 7, 3, 8'hFF);
        n_cmp++; if (b_wr !== 1'b1 || b_addr !== 8'h01 || b_wdata !== 16'hE000) begin n_bad++; $display("FAIL halt_word got wr=%0b addr=%0h data=%0h want 1 1 e000", b_wr, b_addr, b_wdata); end
        @(negedge clk);
        n_cmp++; if (b_done !== 1'b1 || b_ready !== 1'b0 || b_count !== 9'd2) begin n_bad++; $display("FAIL halt_done got done=%0b ready=%0b count=%0d want 1 0 2", b_done, b_ready, b_count); end
        send(12, 0, 0, 0, 0, 0);
        n_cmp++; if (b_wr !== 1'b0 || b_err !== 1'b0 || b_done !== 1'b1) begin n_bad++; $display("FAIL done_ignore got wr=%0b err=%0b done=%0b want 0 0 1", b_wr, b_err, b_done); end
        send(0, 1, 0, 0, 0, 8'h11);
        @(negedge clk);
        n_cmp++; if (b_wr !== 1'b0 || b_count !== 9'd2) begin n_bad++; $display("FAIL done_ignore2 got wr=%0b count=%0d want 0 2", b_wr, b_count); end
    endtask

    task automatic test_back_to_back_full();
        int strobes;
        int last_c;
        do_restart();
        strobes = 0;
        last_c = -10;
        @(negedge clk);
        in_valid = 1'b1; mnem = 4'd0; rn = 3'd1; imm = 8'h00;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (s_wr === 1'b1) begin
                n_cmp++; if (s_addr !== 8'(strobes)) begin n_bad++; $display("FAIL full_addr got %0d want %0d", s_addr, strobes); end
                if (strobes > 0) begin
                    n_cmp++; if (c - last_c != 2) begin n_bad++; $display("FAIL full_spacing got %0d want 2", c - last_c); end
                end
                last_c = c;
                strobes++;
            end
            imm = 8'(c + 1);
        end
        in_valid = 1'b0;
        n_cmp++; if (strobes != 4) begin n_bad++; $display("FAIL full_strobes got %0d want 4", strobes); end
        n_cmp++; if (s_count !== 9'd4 || s_done !== 1'b1 || s_ready !== 1'b0) begin n_bad++; $display("FAIL full_state got count=%0d done=%0b ready=%0b want 4 1 0", s_count, s_done, s_ready); end
        do_restart();
        n_cmp++; if (s_count !== 9'd0 || s_addr !== 8'h00 || s_done !== 1'b0 || s_ready !== 1'b1) begin n_bad++; $display("FAIL full_restart got count=%0d addr=%0d done=%0b ready=%0b want 0 0 0 1", s_count, s_addr, s_done, s_ready); end
        do_restart();
    endtask

    task automatic test_restart_cases();
        // restart during WRITE: strobe finishes, counters return to base
        send(0, 2, 0, 0, 0, 8'h22);
        n_cmp++; if (b_wr !== 1'b1) begin n_bad++; $display("FAIL rs_write_wr got %0b want 1", b_wr); end
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        n_cmp++; if (b_count !== 9'd0 || b_addr !== 8'h00 || b_ready !== 1'b1 || b_wr !== 1'b0) begin n_bad++; $display("FAIL rs_write got count=%0d addr=%0d ready=%0b wr=%0b want 0 0 1 0", b_count, b_addr, b_ready, b_wr); end
        // restart with in_valid in IDLE: tuple is not accepted
        @(negedge clk);
        restart = 1'b1; in_valid = 1'b1; mnem = 4'd0; rn = 3'd3; imm = 8'h55;
        @(negedge clk);
        restart = 1'b0; in_valid = 1'b0;
        n_cmp++; if (b_wr !== 1'b0 || b_count !== 9'd0) begin n_bad++; $display("FAIL rs_valid got wr=%0b count=%0d want 0 0", b_wr, b_count); end
        @(negedge clk);
        n_cmp++; if (b_wr !== 1'b0 || b_ready !== 1'b1) begin n_bad++; $display("FAIL rs_valid2 got wr=%0b ready=%0b want 0 1", b_wr, b_ready); end
    endtask

    task automatic test_reset_mid_write();
        send(0, 0, 0, 0, 0, 8'h01);
        @(negedge clk);
        send(0, 4, 0, 0, 0, 8'h9A);
        n_cmp++; if (b_wr !== 1'b1 || b_count !== 9'd1) begin n_bad++; $display("FAIL rst_pre got wr=%0b count=%0d want 1 1", b_wr, b_count); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (b_wr !== 1'b0 || b_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid got wr=%0b ready=%0b want 0 1", b_wr, b_ready); end
        n_cmp++; if (b_addr !== 8'h00 || b_wdata !== 16'h0000 || b_count !== 9'd0) begin n_bad++; $display("FAIL rst_mid_regs got addr=%0h data=%0h count=%0d want 0 0 0", b_addr, b_wdata, b_count); end
        n_cmp++; if (b_err !== 1'b0 || b_done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_flags got err=%0b done=%0b want 0 0", b_err, b_done); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0; exp_addr = 0; exp_err = 1'b0; exp_done = 1'b0;
    endtask

    task automatic test_random();
        logic [16:0] r;
        int m, a_rn, a_rd, a_rm, a_sh, a_imm, sel;
        do_restart();
        have_w = 0;
        for (int i = 0; i < 120; i++) begin
            sel = $urandom_range(0, 23);
            m = (sel < 16) ? sel : $urandom_range(0, 7);
            a_rn = $urandom_range(0, 7); a_rd = $urandom_range(0, 7);
            a_rm = $urandom_range(0, 7); a_sh = $urandom_range(0, 3);
            a_imm = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255)
                                                : (($urandom_range(0, 31) + 240) % 256);
            r = model_enc(m, a_rn, a_rd, a_rm, a_sh, a_imm);
            send(m, a_rn, a_rd, a_rm, a_sh, a_imm);
            if (exp_done) begin
                n_cmp++; if (b_wr !== 1'b0 || b_done !== 1'b1 || b_count !== 9'(exp_count)) begin n_bad++; $display("FAIL rnd_done[%0d] got wr=%0b done=%0b count=%0d want 0 1 %0d", i, b_wr, b_done, b_count, exp_count); end
                do_restart();
            end else if (r[16]) begin
                n_cmp++; if (b_wr !== 1'b1 || b_addr !== 8'(exp_addr) || b_wdata !== r[15:0]) begin n_bad++; $display("FAIL rnd_write[%0d] m=%0d got wr=%0b addr=%0h data=%0h want 1 %0h %0h", i, m, b_wr, b_addr, b_wdata, exp_addr, r[15:0]); end
                @(negedge clk);
                exp_count++;
                exp_addr = (exp_addr + 1) % 256;
                if (m == 8 || exp_count == 256) exp_done = 1'b1;
                last_w = r[15:0];
                have_w = 1;
                n_cmp++; if (b_wr !== 1'b0 || b_count !== 9'(exp_count) || b_done !== exp_done || b_ready !== !exp_done || b_err !== exp_err) begin n_bad++; $display("FAIL rnd_after[%0d] got wr=%0b count=%0d done=%0b ready=%0b err=%0b want 0 %0d %0b %0b %0b", i, b_wr, b_count, b_done, b_ready, b_err, exp_count, exp_done, !exp_done, exp_err); end
            end else begin
                exp_err = 1'b1;
                n_cmp++; if (b_wr !== 1'b0 || b_err !== 1'b1 || b_count !== 9'(exp_count)) begin n_bad++; $display("FAIL rnd_reject[%0d] m=%0d imm=%0h got wr=%0b err=%0b count=%0d want 0 1 %0d", i, m, a_imm, b_wr, b_err, b_count, exp_count); end
                if (have_w) begin
                    n_cmp++; if (b_wdata !== last_w) begin n_bad++; $display("FAIL rnd_hold[%0d] got %0h want %0h", i, b_wdata, last_w); end
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0;
        mnem = 4'd0; rn = 3'd0; rd = 3'd0; rm = 3'd0; sh = 2'd0; imm = 8'd0;
        exp_count = 0; exp_addr = 0; exp_err = 1'b0; exp_done = 1'b0;
        last_w = 16'h0000; have_w = 0;
        test_reset();
        test_basic();
        test_reject();
        test_halt();
        test_back_to_back_full();
        test_restart_cases();
        test_reset_mid_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
